pwm_key_ctrl_multi: RTL and testbench

Multi-channel PWM generator. Each channel's duty cycle is stepped up or down by debounced key pulses. This is the parametrised successor of pwm_signal: it adds N channels, a second key for stepping down, saturate/wrap modes, debouncing and glitch-free period-boundary duty updates. It sits between the board key inputs and the LED/motor PWM outputs, and runs in the single system clock domain.

---
 rtl/pwm_key_ctrl_multi.sv | 127 ++++++++++++
 tb/tb_pwm_key_ctrl_multi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_key_ctrl_multi.sv
// Multi-channel PWM generator. Each channel's duty is stepped up or down by debounced key presses.
// A duty change reaches its output only at a period boundary, so the outputs never carry runt pulses.
module pwm_key_ctrl_multi #(
    parameter int CHANNELS   = 4,
    parameter int PERIOD     = 256,
    parameter int STEP       = 32,
    parameter int DEBOUNCE   = 4,
    parameter int RESET_DUTY = 128,
    localparam int DW = $clog2(PERIOD + 1),
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_up,
    input  logic                key_down,
    input  logic [SW-1:0]       ch_sel,
    input  logic                wrap_mode,
    output logic [CHANNELS-1:0] pwm,
    output logic [DW-1:0]       duty_sel,
    output logic                period_start
);

    localparam logic [DW-1:0] LAST     = DW'(PERIOD - 1);
    localparam logic [DW-1:0] RST_D    = DW'(RESET_DUTY);
    localparam logic [DW:0]   STEP_X   = (DW+1)'(STEP);
    localparam logic [DW:0]   PERIOD_X = (DW+1)'(PERIOD);
    localparam logic [7:0]    DB_LAST  = 8'(DEBOUNCE - 1);

    logic [DW-1:0] cnt;
    logic [DW-1:0] duty   [CHANNELS];
    logic [DW-1:0] shadow [CHANNELS];

    // Index 0 is the up key, index 1 the down key.
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [1:0] ev;
    logic [7:0] dbc [2];

    logic          sel_valid;
    logic [DW-1:0] cur;
    logic [DW:0]   cur_x;
    logic [DW:0]   up_x;
    logic [DW-1:0] nxt;
    logic          upd;

    assign raw = {key_down, key_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            ev    <= '0;
            for (int k = 0; k < 2; k++) dbc[k] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int k = 0; k < 2; k++) begin
                ev[k] <= 1'b0;
                if (sync2[k] == filt[k]) begin
                    dbc[k] <= '0;
                end else if (dbc[k] == DB_LAST) begin
                    // Level accepted; only a press (new level 1) produces an event.
                    filt[k] <= sync2[k];
                    dbc[k]  <= '0;
                    ev[k]   <= sync2[k];
                end else begin
                    dbc[k] <= dbc[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        cur       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == SW'(i)) begin
                sel_valid = 1'b1;
                cur       = duty[i];
            end
        end
    end

    assign duty_sel     = cur;
    assign period_start = (cnt == '0);
    assign upd          = sel_valid & (ev[0] ^ ev[1]);
    assign cur_x        = {1'b0, cur};
    assign up_x         = cur_x + STEP_X;

    // One bit of headroom keeps duty+STEP and duty+PERIOD+1-STEP exact.
    always_comb begin
        nxt = cur;
        if (ev[0]) begin
            if (up_x > PERIOD_X)
                nxt = wrap_mode ? DW'(up_x - PERIOD_X - (DW+1)'(1)) : DW'(PERIOD_X);
            else
                nxt = DW'(up_x);
        end else begin
            if (cur_x < STEP_X)
                nxt = wrap_mode ? DW'(cur_x + PERIOD_X + (DW+1)'(1) - STEP_X) : '0;
            else
                nxt = DW'(cur_x - STEP_X);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            pwm <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty[i]   <= RST_D;
                shadow[i] <= RST_D;
            end
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + DW'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= (cnt < shadow[i]);
                if (cnt == LAST) shadow[i] <= duty[i];
                if (upd && ch_sel == SW'(i)) duty[i] <= nxt;
            end
        end
    end

endmodule

// File: tb/tb_pwm_key_ctrl_multi.sv
// Directed bench for pwm_key_ctrl_multi: PERIOD=10, STEP=3, DEBOUNCE=4, RESET_DUTY=5.
// A second 3-channel instance shares the keys and covers an out-of-range channel select.
module tb_pwm_key_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up;
    logic       key_down;
    logic [1:0] ch_sel;
    logic [1:0] ch_sel2;
    logic       wrap_mode;
    logic [3:0] pwm;
    logic [3:0] duty_sel;
    logic       period_start;
    logic [2:0] pwm2;
    logic [3:0] duty_sel2;
    logic       period_start2;

    int tests = 0;
    int fails = 0;
    int hi_cnt [4];
    int ps_cnt;

    always #5 clk = ~clk;

    pwm_key_ctrl_multi #(.CHANNELS(4), .PERIOD(10), .STEP(3), .DEBOUNCE(4), .RESET_DUTY(5)) dut (
        .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down), .ch_sel(ch_sel),
        .wrap_mode(wrap_mode), .pwm(pwm), .duty_sel(duty_sel), .period_start(period_start)
    );

    pwm_key_ctrl_multi #(.CHANNELS(3), .PERIOD(10), .STEP(3), .DEBOUNCE(4), .RESET_DUTY(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down), .ch_sel(ch_sel2),
        .wrap_mode(wrap_mode), .pwm(pwm2), .duty_sel(duty_sel2), .period_start(period_start2)
    );

    task automatic press(input logic u, input logic d);
        @(negedge clk);
        key_up   = u;
        key_down = d;
        repeat (10) @(negedge clk);
        key_up   = 1'b0;
        key_down = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic measure();
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        ps_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) hi_cnt[i] += int'(pwm[i]);
            ps_cnt += int'(period_start);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_pwm;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (pwm !== 4'h0 || pwm2 !== 3'h0) begin
            fails++;
            $display("FAIL reset_pwm: got %b/%b expected 0000/000", pwm, pwm2);
        end
        tests++;
        if (duty_sel !== 4'd5 || period_start !== 1'b1 || duty_sel2 !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: duty_sel %0d ps %b duty_sel2 %0d expected 5 1 0",
                     duty_sel, period_start, duty_sel2);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_pwm = (((k - 1) % 10) < 5) ? 4'hF : 4'h0;
            tests++;
            if (pwm !== exp_pwm || pwm2 !== exp_pwm[2:0] || period_start !== (k % 10 == 0)) begin
                fails++;
                $display("FAIL reset_wave k=%0d: pwm %b pwm2 %b ps %b expected %b %b %b",
                         k, pwm, pwm2, period_start, exp_pwm, exp_pwm[2:0], (k % 10 == 0));
            end
        end
    endtask

    task automatic test_up_latency();
        logic [3:0] exp_d;
        int exp_hi [4] = '{5, 5, 8, 5};
        ch_sel = 2'd2;
        @(negedge clk);
        key_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_d = (k < 7) ? 4'd5 : 4'd8;
            tests++;
            if (duty_sel !== exp_d) begin
                fails++;
                $display("FAIL up_latency k=%0d: duty_sel %0d expected %0d", k, duty_sel, exp_d);
            end
        end
        key_up = 1'b0;
        repeat (10) @(negedge clk);
        measure();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (hi_cnt[i] != exp_hi[i]) begin
                fails++;
                $display("FAIL up_pwm ch%0d: high %0d expected %0d", i, hi_cnt[i], exp_hi[i]);
            end
        end
        tests++;
        if (ps_cnt != 1) begin
            fails++;
            $display("FAIL period_start_count: got %0d expected 1", ps_cnt);
        end
    endtask

    task automatic test_bounce();
        int exp_d [4] = '{5, 5, 8, 5};
        repeat (5) begin
            @(negedge clk);
            key_up = 1'b1;
            repeat (3) @(negedge clk);
            key_up = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ch_sel = 2'(i);
            #1;
            tests++;
            if (duty_sel !== 4'(exp_d[i])) begin
                fails++;
                $display("FAIL bounce ch%0d: duty %0d expected %0d", i, duty_sel, exp_d[i]);
            end
        end
        ch_sel = 2'd2;
    endtask

    task automatic test_saturate();
        int exp_seq [6] = '{10, 10, 7, 4, 1, 0};
        wrap_mode = 1'b0;
        ch_sel    = 2'd2;
        for (int s = 0; s < 6; s++) begin
            press(s < 2, s >= 2);
            tests++;
            if (duty_sel !== 4'(exp_seq[s])) begin
                fails++;
                $display("FAIL saturate step%0d: duty %0d expected %0d", s, duty_sel, exp_seq[s]);
            end
            if (s == 1 || s == 5) begin
                measure();
                tests++;
                if (hi_cnt[2] != exp_seq[s]) begin
                    fails++;
                    $display("FAIL saturate_pwm step%0d: high %0d expected %0d", s, hi_cnt[2], exp_seq[s]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_ch1 [3] = '{8, 0, 8};
        int exp_ch3 [6] = '{2, 10, 7, 4, 1, 9};
        wrap_mode = 1'b1;
        ch_sel    = 2'd1;
        for (int s = 0; s < 3; s++) begin
            press(s < 2, s == 2);
            tests++;
            if (duty_sel !== 4'(exp_ch1[s])) begin
                fails++;
                $display("FAIL wrap_ch1 step%0d: duty %0d expected %0d", s, duty_sel, exp_ch1[s]);
            end
        end
        ch_sel = 2'd3;
        for (int s = 0; s < 6; s++) begin
            press(1'b0, 1'b1);
            tests++;
            if (duty_sel !== 4'(exp_ch3[s])) begin
                fails++;
                $display("FAIL wrap_ch3 step%0d: duty %0d expected %0d", s, duty_sel, exp_ch3[s]);
            end
        end
        wrap_mode = 1'b0;
    endtask

    task automatic test_corners();
        ch_sel = 2'd0;
        press(1'b1, 1'b1);
        tests++;
        if (duty_sel !== 4'd5) begin
            fails++;
            $display("FAIL both_keys: duty %0d expected 5", duty_sel);
        end
        ch_sel2 = 2'd3;
        press(1'b1, 1'b0);
        tests++;
        if (duty_sel2 !== 4'd0) begin
            fails++;
            $display("FAIL out_of_range_sel: duty_sel2 %0d expected 0", duty_sel2);
        end
        for (int i = 0; i < 3; i++) begin
            ch_sel2 = 2'(i);
            #1;
            tests++;
            if (duty_sel2 !== 4'd5) begin
                fails++;
                $display("FAIL out_of_range_keep ch%0d: duty %0d expected 5", i, duty_sel2);
            end
        end
        ch_sel2 = 2'd3;
    endtask

    task automatic test_mid_reset();
        int waited = 0;
        @(negedge clk);
        while (period_start !== 1'b1 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (period_start !== 1'b1) begin
            fails++;
            $display("FAIL period_start_timeout: waited %0d cycles expected within 12", waited);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (pwm !== 4'b1011) begin
            fails++;
            $display("FAIL pre_reset_pwm: got %b expected 1011", pwm);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (pwm !== 4'h0) begin
            fails++;
            $display("FAIL async_reset_pwm: got %b expected 0000", pwm);
        end
        for (int i = 0; i < 4; i++) begin
            ch_sel = 2'(i);
            #1;
            tests++;
            if (duty_sel !== 4'd5) begin
                fails++;
                $display("FAIL reset_duty ch%0d: duty %0d expected 5", i, duty_sel);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        measure();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (hi_cnt[i] != 5) begin
                fails++;
                $display("FAIL post_reset_pwm ch%0d: high %0d expected 5", i, hi_cnt[i]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        key_up    = 1'b0;
        key_down  = 1'b0;
        ch_sel    = 2'd0;
        ch_sel2   = 2'd3;
        wrap_mode = 1'b0;
        test_reset();
        test_up_latency();
        test_bounce();
        test_saturate();
        test_wrap();
        test_corners();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
